vector_wb_queue: RTL and testbench

- Writeback stage directly downstream of the vector execution stage.
- Captures each cycle's per-lane writeback (lane enables, destination register, lane data, reduction-done, fflags) into a FIFO.
- Drains entries to the vector register file write port under a valid/ready handshake, and pulses a scoreboard release for each drained destination.
- Holds sticky FP exception flags, and throttles issue before in-flight results can overflow the queue.

---
 rtl/vector_wb_queue_pkg.sv | 16 +
 rtl/vector_wb_queue_fifo.sv | 49 ++++
 rtl/vector_wb_queue.sv | 105 ++++++++++
 tb/tb_vector_wb_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vector_wb_queue_pkg.sv
// Shared types and constants for the vector writeback queue.
// The entry layout is sized from these defaults; the top-level parameters must match them.
package vector_wb_queue_pkg;
  localparam int VWB_LANES    = 8;
  localparam int VWB_XLEN     = 32;
  localparam int VWB_REGS     = 32;
  localparam int VWB_AW       = $clog2(VWB_REGS);
  localparam int VWB_FFLAGS_W = 5;

  typedef struct packed {
    logic [VWB_LANES-1:0]          mask;
    logic [VWB_AW-1:0]             addr;
    logic [VWB_LANES*VWB_XLEN-1:0] data;
    logic                          rdc;
  } vwb_entry_t;
endpackage

// File: rtl/vector_wb_queue_fifo.sv
// Generic power-of-two FIFO with count; a push while full is accepted only alongside a pop.
module vwb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // Storage is left unreset; pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
endmodule

// File: rtl/vector_wb_queue.sv
// Writeback queue between vector execute and the VRF write port: queues lane results,
// drains under valid/ready, releases scoreboard entries, keeps sticky fflags and throttles issue.
module vector_wb_queue
  import vector_wb_queue_pkg::*;
#(
  parameter int VECTOR_REGISTERS = VWB_REGS,
  parameter int VECTOR_LANES     = VWB_LANES,
  parameter int XLEN             = VWB_XLEN,
  parameter int DEPTH            = 8,
  parameter int SKID             = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [VECTOR_LANES-1:0]             wb_en_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] wb_addr_i,
  input  logic [VECTOR_LANES*XLEN-1:0]        wb_data_i,
  input  logic [VECTOR_LANES-1:0]             rdc_done_i,
  input  logic [VWB_FFLAGS_W-1:0]             fflags_i,
  input  logic                                fflags_clr_i,
  output logic                                vrf_wr_valid_o,
  input  logic                                vrf_wr_ready_i,
  output logic [VECTOR_LANES-1:0]             vrf_wr_en_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] vrf_wr_addr_o,
  output logic [VECTOR_LANES*XLEN-1:0]        vrf_wr_data_o,
  output logic                                rel_valid_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] rel_addr_o,
  output logic                                stall_o,
  output logic [VWB_FFLAGS_W-1:0]             fflags_o,
  output logic                                ovf_o,
  output logic                                wb_idle_o
);
  localparam int AW = $clog2(VECTOR_REGISTERS);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(vwb_entry_t);

  vwb_entry_t        w_in;
  vwb_entry_t        w_head;
  logic [EW-1:0]     w_head_bits;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              r_rel_valid;
  logic [AW-1:0]     r_rel_addr;
  logic [VWB_FFLAGS_W-1:0] r_fflags;
  logic              r_ovf;

  // A finished reduction writes only its scalar result in lane 0.
  always_comb begin
    w_in      = '0;
    w_in.addr = wb_addr_i;
    w_in.data = wb_data_i;
    w_in.rdc  = |rdc_done_i;
    w_in.mask = w_in.rdc ? (wb_en_i & VECTOR_LANES'(1)) : wb_en_i;
  end

  assign w_push = |wb_en_i;
  assign w_pop  = vrf_wr_valid_o && vrf_wr_ready_i;

  vwb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (vrf_wr_ready_i),
    .i_data  (w_in),
    .o_data  (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head = vwb_entry_t'(w_head_bits);

  // Port fields are gated by valid so stale, unreset storage never shows on the bus.
  assign vrf_wr_valid_o = !w_empty;
  assign vrf_wr_en_o    = vrf_wr_valid_o ?
                          (w_head.mask & (w_head.rdc ? VECTOR_LANES'(1) : {VECTOR_LANES{1'b1}})) : '0;
  assign vrf_wr_addr_o  = vrf_wr_valid_o ? w_head.addr : '0;
  assign vrf_wr_data_o  = vrf_wr_valid_o ? w_head.data : '0;

  assign stall_o     = (DEPTH - int'(w_count)) <= SKID;
  assign wb_idle_o   = w_empty;
  assign rel_valid_o = r_rel_valid;
  assign rel_addr_o  = r_rel_addr;
  assign fflags_o    = r_fflags;
  assign ovf_o       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel_valid <= 1'b0;
      r_rel_addr  <= '0;
      r_fflags    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_rel_valid <= w_pop;
      if (w_pop) r_rel_addr <= w_head.addr;
      r_fflags <= fflags_clr_i ? fflags_i : (r_fflags | fflags_i);
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vector_wb_queue.sv
// Randomized bench for vector_wb_queue against a queue-based reference model.
module tb_vector_wb_queue;
  localparam int L  = 8;
  localparam int X  = 32;
  localparam int DW = L*X;
  localparam int D  = 8;
  localparam int SK = 5;

  typedef struct {
    logic [L-1:0]  mask;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } ment_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [L-1:0]  wb_en_i = '0;
  logic [4:0]    wb_addr_i = '0;
  logic [DW-1:0] wb_data_i = '0;
  logic [L-1:0]  rdc_done_i = '0;
  logic [4:0]    fflags_i = '0;
  logic          fflags_clr_i = 1'b0;
  logic          vrf_wr_ready_i = 1'b0;
  logic          vrf_wr_valid_o;
  logic [L-1:0]  vrf_wr_en_o;
  logic [4:0]    vrf_wr_addr_o;
  logic [DW-1:0] vrf_wr_data_o;
  logic          rel_valid_o;
  logic [4:0]    rel_addr_o;
  logic          stall_o;
  logic [4:0]    fflags_o;
  logic          ovf_o;
  logic          wb_idle_o;

  vector_wb_queue dut (
    .clk(clk), .rst(rst), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rdc_done_i(rdc_done_i), .fflags_i(fflags_i), .fflags_clr_i(fflags_clr_i),
    .vrf_wr_valid_o(vrf_wr_valid_o), .vrf_wr_ready_i(vrf_wr_ready_i), .vrf_wr_en_o(vrf_wr_en_o),
    .vrf_wr_addr_o(vrf_wr_addr_o), .vrf_wr_data_o(vrf_wr_data_o), .rel_valid_o(rel_valid_o),
    .rel_addr_o(rel_addr_o), .stall_o(stall_o), .fflags_o(fflags_o), .ovf_o(ovf_o),
    .wb_idle_o(wb_idle_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  ment_t      m_q[$];
  logic       m_ovf;
  logic [4:0] m_ff;
  logic       m_rel_v;
  logic [4:0] m_rel_a;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_ff = '0; m_rel_v = 1'b0; m_rel_a = '0;
  endtask

  task automatic check_outputs();
    bit has = (m_q.size() != 0);
    chk("valid",  DW'(vrf_wr_valid_o), DW'(has));
    chk("en",     DW'(vrf_wr_en_o),    has ? DW'(m_q[0].mask) : '0);
    chk("addr",   DW'(vrf_wr_addr_o),  has ? DW'(m_q[0].addr) : '0);
    chk("data",   vrf_wr_data_o,       has ? m_q[0].data : '0);
    chk("rel_v",  DW'(rel_valid_o),    DW'(m_rel_v));
    chk("rel_a",  DW'(rel_addr_o),     DW'(m_rel_a));
    chk("stall",  DW'(stall_o),        DW'((D - m_q.size()) <= SK));
    chk("idle",   DW'(wb_idle_o),      DW'(m_q.size() == 0));
    chk("fflags", DW'(fflags_o),       DW'(m_ff));
    chk("ovf",    DW'(ovf_o),          DW'(m_ovf));
  endtask

  // Next-state of the reference: pop from the front, then append the new beat.
  task automatic model_step();
    ment_t e;
    bit pop  = (m_q.size() > 0) && vrf_wr_ready_i;
    bit push = |wb_en_i;
    m_rel_v = pop;
    if (pop) begin
      m_rel_a = m_q[0].addr;
      void'(m_q.pop_front());
    end
    if (push) begin
      if (m_q.size() >= D) m_ovf = 1'b1;
      else begin
        e.mask = (|rdc_done_i) ? (wb_en_i & 8'h01) : wb_en_i;
        e.addr = wb_addr_i;
        e.data = wb_data_i;
        m_q.push_back(e);
      end
    end
    m_ff = fflags_clr_i ? fflags_i : (m_ff | fflags_i);
  endtask

  task automatic cyc(input logic [L-1:0] en, input logic [4:0] addr, input logic [DW-1:0] data,
                     input logic [L-1:0] rdc, input logic [4:0] ff, input logic clr, input logic rdy);
    @(negedge clk);
    wb_en_i = en; wb_addr_i = addr; wb_data_i = data; rdc_done_i = rdc;
    fflags_i = ff; fflags_clr_i = clr; vrf_wr_ready_i = rdy;
    #1;
    check_outputs();
    model_step();
  endtask

  function automatic logic [DW-1:0] ramp();
    logic [DW-1:0] d;
    for (int k = 0; k < L; k++) d[k*X +: X] = X'(k+1);
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < L; k++) d[k*X +: X] = $urandom;
    return d;
  endfunction

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    #1 check_outputs();
    rst = 1'b0;

    // single push, drained straight away
    cyc(8'hFF, 5'd3, ramp(), 8'h00, 5'd0, 1'b0, 1'b1);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);
    chk("lane5", DW'(vrf_wr_data_o[5*X +: X]), DW'(6));
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);
    chk("rel3", DW'(rel_addr_o), DW'(3));

    // reduction beat keeps lane 0 only
    cyc(8'hFF, 5'd9, ramp(), 8'h01, 5'd0, 1'b0, 1'b0);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b0);
    chk("rdc_mask", DW'(vrf_wr_en_o), DW'(8'h01));
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);

    // backpressure: fill, overflow, then full push+pop and drain
    for (int i = 0; i < 9; i++) cyc(8'hFF, 5'(i), rnd_data(), 8'h00, 5'd0, 1'b0, 1'b0);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b0);
    chk("ovf_set", DW'(ovf_o), DW'(1));
    for (int i = 0; i < 3; i++) cyc(8'h0F, 5'(20+i), rnd_data(), 8'h00, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);

    // sticky flags and clear-with-new
    cyc(8'h00, 5'd0, '0, 8'h00, 5'b00001, 1'b0, 1'b1);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'b10000, 1'b0, 1'b1);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'b00100, 1'b1, 1'b1);
    chk("ff_or", DW'(fflags_o), DW'(5'b10001));
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);
    chk("ff_clr", DW'(fflags_o), DW'(5'b00100));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [L-1:0] en  = ($urandom_range(0, 3) == 0) ? 8'h00 : L'($urandom);
      logic [L-1:0] rdc = ($urandom_range(0, 7) == 0) ? L'($urandom) : 8'h00;
      logic [4:0]   ff  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      logic         clr = ($urandom_range(0, 15) == 0);
      logic         rdy = ($urandom_range(0, 99) < ((n / 500) % 2 == 0 ? 70 : 35));
      cyc(en, 5'($urandom), rnd_data(), rdc, ff, clr, rdy);
    end

    // reset with four entries queued
    for (int i = 0; i < 4; i++) cyc(8'h3C, 5'(10+i), rnd_data(), 8'h00, 5'd3, 1'b0, 1'b0);
    @(negedge clk);
    wb_en_i = '0; vrf_wr_ready_i = 1'b1; fflags_i = '0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);
    cyc(8'h01, 5'd31, rnd_data(), 8'h00, 5'd0, 1'b0, 1'b1);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);
    cyc(8'h00, 5'd0, '0, 8'h00, 5'd0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
